// File: rtl/cpu_oci_dct_trace_monitor.sv
// ----------------------------------------------------------------------------
// cpu_oci_dct_trace_monitor
//
// Purpose:
//   Collects data-trace (DCT) snapshots from several CPU cores, stamps each one
//   with the cycle it was captured on, and merges them round-robin into a single
//   show-ahead FIFO that a valid/ready reader drains. Snapshots that arrive while
//   a channel's one-deep pending slot is still occupied are dropped and counted.
//   A test_ending request freezes capture; once everything already captured has
//   been drained, test_has_ended goes high and stays high until reset.
//
// Ports:
//   i_clk             system clock
//   i_reset           synchronous, active-high reset
//   i_dct_buffer      per-channel snapshot, channel i at [i*DCT_W +: DCT_W]
//   i_dct_count       per-channel count, channel i at [i*CNT_W +: CNT_W]
//   i_dct_valid       per-channel capture strobe
//   i_test_ending     request to stop capture and drain
//   i_rd_ready        reader accepts the head entry
//   o_rd_valid        FIFO head valid
//   o_rd_ch           head channel index
//   o_rd_count        head dct_count
//   o_rd_data         head dct_buffer
//   o_rd_ts           head timestamp (cycle the strobe was seen)
//   o_fifo_level      number of entries held (0..FIFO_DEPTH)
//   o_drop_count      total dropped snapshots, saturating
//   o_drop_flags      sticky per-channel drop indicator
//   o_test_has_ended  capture stopped and fully drained, sticky
// ----------------------------------------------------------------------------
module cpu_oci_dct_trace_monitor #(
   parameter int NUM_CH     = 6,
   parameter int DCT_W      = 30,
   parameter int CNT_W      = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int TS_W       = 16
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [NUM_CH*DCT_W-1:0]      i_dct_buffer,
   input  logic [NUM_CH*CNT_W-1:0]      i_dct_count,
   input  logic [NUM_CH-1:0]            i_dct_valid,
   input  logic                         i_test_ending,
   input  logic                         i_rd_ready,
   output logic                         o_rd_valid,
   output logic [3:0]                   o_rd_ch,
   output logic [CNT_W-1:0]             o_rd_count,
   output logic [DCT_W-1:0]             o_rd_data,
   output logic [TS_W-1:0]              o_rd_ts,
   output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
   output logic [15:0]                  o_drop_count,
   output logic [NUM_CH-1:0]            o_drop_flags,
   output logic                         o_test_has_ended
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int PEND_W  = CNT_W + DCT_W + TS_W;
   localparam int ENTRY_W = 4 + PEND_W;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_ENDED
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic                w_ending;
   logic                w_hasEnded;

   logic [TS_W-1:0]     r_ts;

   logic [NUM_CH-1:0]   r_pendValid;
   logic [PEND_W-1:0]   r_pendData [NUM_CH];
   logic [3:0]          r_rrPtr;

   logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wrPtr;
   logic [PTR_W-1:0]    r_rdPtr;
   logic [LVL_W-1:0]    r_level;

   logic [15:0]         r_dropCount;
   logic [NUM_CH-1:0]   r_dropFlags;

   logic                w_pop;
   logic                w_full;
   logic                w_accept;
   logic                w_grantValid;
   logic [3:0]          w_grantCh;
   logic [PEND_W-1:0]   w_grantData;
   logic [NUM_CH-1:0]   w_isGrant;
   logic [NUM_CH-1:0]   w_load;
   logic [NUM_CH-1:0]   w_drop;
   logic [4:0]          w_dropNum;
   logic [16:0]         w_dropSum;
   logic [ENTRY_W-1:0]  w_head;

   // The reader pops only a real head entry; a full FIFO can still take a new
   // entry in the same cycle it gives one away, so the arbiter sees that as room.
   assign w_pop    = (r_level != '0) && i_rd_ready;
   assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_accept = !w_full || w_pop;

   // Free-running timestamp; it simply wraps through zero at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + TS_W'(1);
      end
   end

   // Round-robin search starting at r_rrPtr. Two descending passes: the first
   // picks the lowest pending channel below the pointer, the second overrides it
   // with the lowest pending channel at or above the pointer, which wins.
   always_comb begin
      w_grantValid = 1'b0;
      w_grantCh    = '0;
      w_grantData  = '0;
      if (w_accept) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pendValid[i] && (4'(i) < r_rrPtr)) begin
               w_grantValid = 1'b1;
               w_grantCh    = 4'(i);
               w_grantData  = r_pendData[i];
            end
         end
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pendValid[i] && (4'(i) >= r_rrPtr)) begin
               w_grantValid = 1'b1;
               w_grantCh    = 4'(i);
               w_grantData  = r_pendData[i];
            end
         end
      end
   end

   // Per-channel capture decision. A slot being granted this cycle counts as
   // free, so a back-to-back strobe refills it instead of being dropped.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_capture
      assign w_isGrant[gi] = w_grantValid && (w_grantCh == 4'(gi));
      assign w_load[gi]    = i_dct_valid[gi] && !w_ending &&
                             (!r_pendValid[gi] || w_isGrant[gi]);
      assign w_drop[gi]    = i_dct_valid[gi] && !w_ending &&
                             r_pendValid[gi] && !w_isGrant[gi];
   end

   // Pending-slot occupancy: a new capture wins over a grant clearing the slot.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pendValid <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_load[i]) begin
               r_pendValid[i] <= 1'b1;
            end else if (w_isGrant[i]) begin
               r_pendValid[i] <= 1'b0;
            end
         end
      end
   end

   // Pending payload; its contents only matter while the matching valid bit is
   // set, so it carries no reset.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_load[i]) begin
            r_pendData[i] <= {i_dct_count[i*CNT_W +: CNT_W],
                              i_dct_buffer[i*DCT_W +: DCT_W], r_ts};
         end
      end
   end

   // After a grant the next search begins one channel past the winner.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rrPtr <= '0;
      end else if (w_grantValid) begin
         r_rrPtr <= (w_grantCh == 4'(NUM_CH - 1)) ? 4'd0 : w_grantCh + 4'd1;
      end
   end

   // FIFO storage; the granted channel index is stored alongside its payload.
   always_ff @(posedge i_clk) begin
      if (w_grantValid) begin
         r_mem[r_wrPtr] <= {w_grantCh, w_grantData};
      end
   end

   // FIFO pointers and exact occupancy. Push and pop together leave the level
   // unchanged, which is what keeps a full FIFO full while it streams.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_grantValid) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         unique case ({w_grantValid, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Drop accounting: several channels may drop in one cycle, so the total is
   // added in one step and clamped at all-ones.
   always_comb begin
      w_dropNum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_dropNum = w_dropNum + 5'(w_drop[i]);
      end
      w_dropSum = {1'b0, r_dropCount} + 17'(w_dropNum);
   end

   // Saturating drop counter and sticky per-channel drop flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_dropCount <= '0;
         r_dropFlags <= '0;
      end else begin
         r_dropCount <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
         r_dropFlags <= r_dropFlags | w_drop;
      end
   end

   // End-of-test state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // End-of-test sequencing: RUN captures normally, DRAIN refuses new snapshots
   // but keeps arbitrating and reading, ENDED is reached once nothing is left
   // anywhere and then holds until reset. Further test_ending pulses are moot.
   always_comb begin
      w_stateNext = r_state;
      w_ending    = 1'b0;
      w_hasEnded  = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (i_test_ending) begin
               w_stateNext = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_ending = 1'b1;
            if (!(|r_pendValid) && (r_level == '0)) begin
               w_stateNext = ST_ENDED;
            end
         end
         ST_ENDED: begin
            w_ending   = 1'b1;
            w_hasEnded = 1'b1;
         end
         default: begin
            w_stateNext = ST_RUN;
         end
      endcase
   end

   // Show-ahead read port straight from the storage registers, forced to zero
   // while empty so stale memory never reaches the outputs.
   assign w_head           = r_mem[r_rdPtr];
   assign o_rd_valid       = (r_level != '0);
   assign o_rd_ch          = o_rd_valid ? w_head[ENTRY_W-1 -: 4] : '0;
   assign o_rd_count       = o_rd_valid ? w_head[PEND_W-1 -: CNT_W] : '0;
   assign o_rd_data        = o_rd_valid ? w_head[DCT_W+TS_W-1 -: DCT_W] : '0;
   assign o_rd_ts          = o_rd_valid ? w_head[TS_W-1:0] : '0;
   assign o_fifo_level     = r_level;
   assign o_drop_count     = r_dropCount;
   assign o_drop_flags     = r_dropFlags;
   assign o_test_has_ended = w_hasEnded;

endmodule

// File: tb/tb_cpu_oci_dct_trace_monitor.sv
// ----------------------------------------------------------------------------
// tb_cpu_oci_dct_trace_monitor
//
// Purpose:
//   Self-checking bench for cpu_oci_dct_trace_monitor. A queue-based reference
//   model advances once per clock edge from the same inputs the design sees;
//   each scenario task drives stimulus and compares outputs on the falling edge.
// ----------------------------------------------------------------------------
module tb_cpu_oci_dct_trace_monitor;

   localparam int NUM_CH     = 6;
   localparam int DCT_W      = 30;
   localparam int CNT_W      = 4;
   localparam int FIFO_DEPTH = 16;
   localparam int TS_W       = 16;
   localparam int LVL_W      = 5;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic [NUM_CH*DCT_W-1:0] dctBuffer = '0;
   logic [NUM_CH*CNT_W-1:0] dctCount = '0;
   logic [NUM_CH-1:0]       dctValid = '0;
   logic                    testEnding = 1'b0;
   logic                    rdReady = 1'b0;
   logic                    rdValid;
   logic [3:0]              rdCh;
   logic [CNT_W-1:0]        rdCount;
   logic [DCT_W-1:0]        rdData;
   logic [TS_W-1:0]         rdTs;
   logic [LVL_W-1:0]        fifoLevel;
   logic [15:0]             dropCount;
   logic [NUM_CH-1:0]       dropFlags;
   logic                    hasEnded;

   typedef struct {
      logic [3:0]       ch;
      logic [CNT_W-1:0] cnt;
      logic [DCT_W-1:0] data;
      logic [TS_W-1:0]  ts;
   } entry_t;

   entry_t            mQ[$];
   entry_t            mPendE [NUM_CH];
   bit                mPendV [NUM_CH];
   int                mRr;
   bit                mEnding;
   bit                mHasEnded;
   int                mDrops;
   logic [NUM_CH-1:0] mFlags;
   logic [TS_W-1:0]   mTs;

   int checks   = 0;
   int failures = 0;

   cpu_oci_dct_trace_monitor dut (
      .i_clk            (clock),
      .i_reset          (reset),
      .i_dct_buffer     (dctBuffer),
      .i_dct_count      (dctCount),
      .i_dct_valid      (dctValid),
      .i_test_ending    (testEnding),
      .i_rd_ready       (rdReady),
      .o_rd_valid       (rdValid),
      .o_rd_ch          (rdCh),
      .o_rd_count       (rdCount),
      .o_rd_data        (rdData),
      .o_rd_ts          (rdTs),
      .o_fifo_level     (fifoLevel),
      .o_drop_count     (dropCount),
      .o_drop_flags     (dropFlags),
      .o_test_has_ended (hasEnded)
   );

   // Free-running 100 MHz-style clock.
   always #5 clock = ~clock;

   // Abstract reference: a queue for the merged FIFO, one slot per channel,
   // round-robin picked by distance from the last winner.
   task automatic modelStep();
      bit popNow;
      bit acceptNow;
      bit anyPend;
      bit endNow;
      int g;
      int c;
      if (reset) begin
         mQ.delete();
         for (int i = 0; i < NUM_CH; i++) mPendV[i] = 1'b0;
         mRr = 0; mEnding = 1'b0; mHasEnded = 1'b0;
         mDrops = 0; mFlags = '0; mTs = '0;
         return;
      end
      popNow    = (mQ.size() > 0) && rdReady;
      acceptNow = (mQ.size() < FIFO_DEPTH) || popNow;
      anyPend   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) anyPend |= mPendV[i];
      endNow = mEnding && !anyPend && (mQ.size() == 0);
      g = -1;
      if (acceptNow) begin
         for (int k = 0; k < NUM_CH; k++) begin
            c = (mRr + k) % NUM_CH;
            if (g < 0 && mPendV[c]) g = c;
         end
      end
      if (popNow) void'(mQ.pop_front());
      if (g >= 0) begin
         mQ.push_back(mPendE[g]);
         mPendV[g] = 1'b0;
         mRr = (g + 1) % NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (dctValid[i] && !mEnding) begin
            if (mPendV[i]) begin
               mDrops = (mDrops < 65535) ? mDrops + 1 : 65535;
               mFlags[i] = 1'b1;
            end else begin
               mPendV[i]      = 1'b1;
               mPendE[i].ch   = 4'(i);
               mPendE[i].cnt  = dctCount[i*CNT_W +: CNT_W];
               mPendE[i].data = dctBuffer[i*DCT_W +: DCT_W];
               mPendE[i].ts   = mTs;
            end
         end
      end
      if (endNow) mHasEnded = 1'b1;
      if (testEnding) mEnding = 1'b1;
      mTs = mTs + TS_W'(1);
   endtask

   // One clock: model follows the rising edge, outputs are sampled on the fall.
   task automatic tick();
      @(posedge clock);
      modelStep();
      @(negedge clock);
   endtask

   // Drive a strobe mask with fresh random payloads on every channel.
   task automatic driveValids(input logic [NUM_CH-1:0] mask);
      logic [31:0] rnd;
      dctValid = mask;
      for (int i = 0; i < NUM_CH; i++) begin
         rnd = $urandom;
         dctBuffer[i*DCT_W +: DCT_W] = rnd[DCT_W-1:0];
         rnd = $urandom;
         dctCount[i*CNT_W +: CNT_W] = rnd[CNT_W-1:0];
      end
   endtask

   task automatic applyReset();
      reset = 1'b1; testEnding = 1'b0; rdReady = 1'b0;
      driveValids('0);
      tick(); tick();
      reset = 1'b0;
   endtask

   // Everything reads zero straight out of reset and one cycle later.
   task automatic test_reset();
      applyReset();
      checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %0b expected 0", rdValid); end
      checks++; if (fifoLevel !== '0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", fifoLevel); end
      checks++; if (dropCount !== '0) begin failures++; $display("[TB] FAIL reset_drop_count: got %0d expected 0", dropCount); end
      checks++; if (dropFlags !== '0) begin failures++; $display("[TB] FAIL reset_drop_flags: got %b expected 0", dropFlags); end
      checks++; if (hasEnded !== 1'b0) begin failures++; $display("[TB] FAIL reset_has_ended: got %0b expected 0", hasEnded); end
      checks++; if ({rdCh, rdCount, rdData, rdTs} !== '0) begin failures++; $display("[TB] FAIL reset_rd_fields: got %0h expected 0", {rdCh, rdCount, rdData, rdTs}); end
      tick();
      checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_valid: got %0b expected 0", rdValid); end
   endtask

   // One ch0 snapshot appears two cycles after its strobe with its capture ts.
   task automatic test_single();
      logic [TS_W-1:0]  tsExp;
      logic [DCT_W-1:0] dataExp;
      rdReady = 1'b1;
      driveValids(6'b000001);
      tsExp   = mTs;
      dataExp = dctBuffer[DCT_W-1:0];
      tick();
      driveValids('0);
      checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_valid: got %0b expected 0", rdValid); end
      tick();
      checks++; if (rdValid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid: got %0b expected 1", rdValid); end
      checks++; if (rdCh !== 4'd0) begin failures++; $display("[TB] FAIL single_ch: got %0d expected 0", rdCh); end
      checks++; if (rdTs !== tsExp) begin failures++; $display("[TB] FAIL single_ts: got %0h expected %0h", rdTs, tsExp); end
      checks++; if (rdData !== dataExp) begin failures++; $display("[TB] FAIL single_data: got %0h expected %0h", rdData, dataExp); end
      tick();
      checks++; if (fifoLevel !== '0) begin failures++; $display("[TB] FAIL single_drained: got %0d expected 0", fifoLevel); end
   endtask

   // Two all-channel bursts each come out ch0..ch5.
   task automatic test_burst();
      int order[$];
      applyReset();
      rdReady = 1'b1;
      for (int c = 0; c < 30; c++) begin
         driveValids((c == 0 || c == 8) ? 6'b111111 : 6'b000000);
         tick();
         if (rdValid === 1'b1) begin
            order.push_back(int'(rdCh));
            checks++;
            if (mQ.size() == 0 || rdData !== mQ[0].data) begin
               failures++; $display("[TB] FAIL burst_data: got %0h at cycle %0d", rdData, c);
            end
         end
      end
      checks++; if (order.size() != 12) begin failures++; $display("[TB] FAIL burst_count: got %0d expected 12", order.size()); end
      for (int i = 0; i < order.size() && i < 12; i++) begin
         checks++; if (order[i] != i % NUM_CH) begin failures++; $display("[TB] FAIL burst_order[%0d]: got %0d expected %0d", i, order[i], i % NUM_CH); end
      end
   endtask

   // Blocked reader, ch2 every cycle: 16 queued + 1 pending, the rest dropped.
   task automatic test_backpressure();
      int n;
      applyReset();
      rdReady = 1'b0;
      for (int c = 0; c < 30; c++) begin
         driveValids(6'b000100);
         tick();
      end
      driveValids('0);
      checks++; if (fifoLevel !== 5'd16) begin failures++; $display("[TB] FAIL bp_level: got %0d expected 16", fifoLevel); end
      checks++; if (dropCount !== 16'd13) begin failures++; $display("[TB] FAIL bp_drop_count: got %0d expected 13", dropCount); end
      checks++; if (dropFlags !== 6'b000100) begin failures++; $display("[TB] FAIL bp_drop_flags: got %b expected 000100", dropFlags); end
      rdReady = 1'b1;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (rdValid === 1'b1) begin
            n++;
            checks++;
            if (mQ.size() == 0 || {rdCh, rdCount, rdData, rdTs} !== {mQ[0].ch, mQ[0].cnt, mQ[0].data, mQ[0].ts} || rdCh !== 4'd2) begin
               failures++; $display("[TB] FAIL bp_entry[%0d]: got ch=%0d ts=%0h", n, rdCh, rdTs);
            end
         end
         tick();
      end
      checks++; if (n != 17) begin failures++; $display("[TB] FAIL bp_read_count: got %0d expected 17", n); end
   endtask

   // Full FIFO plus waiting pending: pop and grant together keep level at 16,
   // and the captured timestamps come out consecutive.
   task automatic test_full_pop_grant();
      logic [TS_W-1:0] ts0;
      int n;
      applyReset();
      rdReady = 1'b0;
      ts0 = mTs;
      for (int c = 0; c < 17; c++) begin
         driveValids(6'b001000);
         tick();
      end
      driveValids('0);
      checks++; if (fifoLevel !== 5'd16) begin failures++; $display("[TB] FAIL fpg_level_full: got %0d expected 16", fifoLevel); end
      checks++; if (dropCount !== 16'd0) begin failures++; $display("[TB] FAIL fpg_drops: got %0d expected 0", dropCount); end
      rdReady = 1'b1;
      tick();
      checks++; if (fifoLevel !== 5'd16) begin failures++; $display("[TB] FAIL fpg_level_held: got %0d expected 16", fifoLevel); end
      n = 1;
      for (int c = 0; c < 30 && rdValid === 1'b1; c++) begin
         checks++;
         if (rdCh !== 4'd3 || rdTs !== TS_W'(ts0 + TS_W'(n))) begin
            failures++; $display("[TB] FAIL fpg_order[%0d]: got ch=%0d ts=%0h expected ch=3 ts=%0h", n, rdCh, rdTs, TS_W'(ts0 + TS_W'(n)));
         end
         n++;
         tick();
      end
      checks++; if (n != 17) begin failures++; $display("[TB] FAIL fpg_total: got %0d expected 17", n); end
   endtask

   // test_ending with three entries queued: same-cycle ch1 kept, next ignored,
   // has_ended rises one cycle after the FIFO empties and stays up.
   task automatic test_ending();
      int order[$];
      int expOrder[4] = '{0, 3, 5, 1};
      applyReset();
      rdReady = 1'b0;
      driveValids(6'b101001);
      tick();
      driveValids('0);
      tick(); tick(); tick();
      testEnding = 1'b1;
      driveValids(6'b000010);
      tick();
      testEnding = 1'b0;
      driveValids(6'b000010);
      tick();
      driveValids('0);
      tick(); tick();
      checks++; if (fifoLevel !== 5'd4) begin failures++; $display("[TB] FAIL end_level: got %0d expected 4", fifoLevel); end
      checks++; if (hasEnded !== 1'b0) begin failures++; $display("[TB] FAIL end_early: got %0b expected 0", hasEnded); end
      rdReady = 1'b1;
      for (int c = 0; c < 10 && rdValid === 1'b1; c++) begin
         order.push_back(int'(rdCh));
         tick();
      end
      checks++; if (order.size() != 4) begin failures++; $display("[TB] FAIL end_read_count: got %0d expected 4", order.size()); end
      for (int i = 0; i < order.size() && i < 4; i++) begin
         checks++; if (order[i] != expOrder[i]) begin failures++; $display("[TB] FAIL end_order[%0d]: got %0d expected %0d", i, order[i], expOrder[i]); end
      end
      checks++; if (hasEnded !== 1'b0) begin failures++; $display("[TB] FAIL end_at_last_pop: got %0b expected 0", hasEnded); end
      tick();
      checks++; if (hasEnded !== 1'b1) begin failures++; $display("[TB] FAIL end_rise: got %0b expected 1", hasEnded); end
      testEnding = 1'b1;
      driveValids(6'b111111);
      tick();
      testEnding = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      driveValids('0);
      checks++; if (hasEnded !== 1'b1 || rdValid !== 1'b0) begin failures++; $display("[TB] FAIL end_sticky: got ended=%0b valid=%0b expected 1/0", hasEnded, rdValid); end
   endtask

   // Random strobes and reader stalls, every output compared each cycle.
   task automatic test_random();
      logic [31:0] rnd;
      int qs;
      applyReset();
      for (int c = 0; c < 400; c++) begin
         rnd = $urandom;
         driveValids(rnd[NUM_CH-1:0] & rnd[NUM_CH+7:8]);
         rdReady = (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         tick();
         qs = mQ.size();
         checks++; if (rdValid !== (qs != 0)) begin failures++; $display("[TB] FAIL rand_valid c%0d: got %0b expected %0b", c, rdValid, qs != 0); end
         checks++; if (fifoLevel !== LVL_W'(qs)) begin failures++; $display("[TB] FAIL rand_level c%0d: got %0d expected %0d", c, fifoLevel, qs); end
         checks++; if (dropCount !== 16'(mDrops) || dropFlags !== mFlags) begin failures++; $display("[TB] FAIL rand_drops c%0d: got %0d/%b expected %0d/%b", c, dropCount, dropFlags, mDrops, mFlags); end
         checks++; if (hasEnded !== mHasEnded) begin failures++; $display("[TB] FAIL rand_ended c%0d: got %0b expected %0b", c, hasEnded, mHasEnded); end
         if (qs != 0) begin
            checks++;
            if ({rdCh, rdCount, rdData, rdTs} !== {mQ[0].ch, mQ[0].cnt, mQ[0].data, mQ[0].ts}) begin
               failures++; $display("[TB] FAIL rand_head c%0d: got ch=%0d ts=%0h expected ch=%0d ts=%0h", c, rdCh, rdTs, mQ[0].ch, mQ[0].ts);
            end
         end
      end
   endtask

   // Timestamps wrap through zero; a mid-burst reset wipes all state.
   task automatic test_ts_wrap();
      logic [TS_W-1:0] seen[$];
      int guard;
      applyReset();
      rdReady = 1'b1;
      guard = 0;
      while (mTs != 16'hFFFC && guard < 70000) begin
         tick();
         guard++;
      end
      checks++; if (guard >= 70000) begin failures++; $display("[TB] FAIL wrap_timeout: got %0d cycles", guard); end
      for (int c = 0; c < 14; c++) begin
         driveValids((c < 8) ? 6'b000001 : 6'b000000);
         tick();
         if (rdValid === 1'b1) seen.push_back(rdTs);
      end
      checks++; if (seen.size() != 8) begin failures++; $display("[TB] FAIL wrap_count: got %0d expected 8", seen.size()); end
      for (int k = 0; k < seen.size() && k < 8; k++) begin
         checks++; if (seen[k] !== TS_W'(16'hFFFC + k)) begin failures++; $display("[TB] FAIL wrap_ts[%0d]: got %0h expected %0h", k, seen[k], TS_W'(16'hFFFC + k)); end
      end
      rdReady = 1'b0;
      for (int c = 0; c < 6; c++) begin
         driveValids(6'b111111);
         tick();
      end
      checks++; if (dropCount !== 16'(mDrops) || mDrops == 0) begin failures++; $display("[TB] FAIL wrap_pre_drops: got %0d expected %0d", dropCount, mDrops); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if ({rdValid, fifoLevel, dropCount, dropFlags, hasEnded} !== '0) begin failures++; $display("[TB] FAIL midreset_clear: got valid=%0b lvl=%0d drops=%0d flags=%b ended=%0b", rdValid, fifoLevel, dropCount, dropFlags, hasEnded); end
      tick();
      driveValids('0);
      checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid: got %0b expected 0", rdValid); end
      testEnding = 1'b1;
      tick();
      testEnding = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (hasEnded !== 1'b0) begin failures++; $display("[TB] FAIL reset_clears_ended: got %0b expected 0", hasEnded); end
   endtask

   // Scenario sequence and summary.
   initial begin
      @(negedge clock);
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_full_pop_grant();
      test_ending();
      test_random();
      test_ts_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case a scenario never returns.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
